// File: rtl/spi_flash_pkg.sv
// Shared constants, FSM state type and command-word helper for the SPI flash stream reader.
// Optional feature macro: SPI_FAST_READ_EN (selects FAST_READ opcode and dummy phase in the top).
package spi_flash_pkg;

    localparam logic [7:0]  CMD_READ      = 8'h03;
    localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
    localparam int unsigned ADDR_BITS     = 24;
    localparam int unsigned DUMMY_BITS    = 8;
    localparam int unsigned CMD_BITS      = 8 + ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DUMMY,
        ST_DATA,
        ST_END
    } state_t;

    function automatic logic [CMD_BITS-1:0] cmd_word(
        input logic [7:0]           opcode,
        input logic [ADDR_BITS-1:0] flash_addr
    );
        return {opcode, flash_addr};
    endfunction

endpackage

// File: rtl/spi_bit_shifter.sv
// SPI mode-0 bit engine: toggles SCLK at clk/2, shifts the command word out MSB first
// and samples MISO into an 8-bit register on each rising SCLK edge; pause holds SCLK low.
module spi_bit_shifter
    import spi_flash_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic [CMD_BITS-1:0] load_word,
    input  logic                enable,
    input  logic                pause,
    input  logic                miso,
    output logic                sclk,
    output logic                mosi,
    output logic [7:0]          rx_byte,
    output logic                rise,
    output logic                fall
);

    logic [CMD_BITS-1:0] out_shift;

    // A pause only ever blocks the low->high transition; a high phase always completes.
    assign rise = enable && !sclk && !pause;
    assign fall = enable && sclk;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            out_shift <= '0;
            rx_byte   <= '0;
        end else if (load) begin
            sclk      <= 1'b0;
            mosi      <= load_word[CMD_BITS-1];
            out_shift <= {load_word[CMD_BITS-2:0], 1'b0};
            rx_byte   <= '0;
        end else if (rise) begin
            sclk      <= 1'b1;
            rx_byte   <= {rx_byte[6:0], miso};
        end else if (fall) begin
            // Zeros follow the command word, so MOSI stays low through dummy and data phases.
            sclk      <= 1'b0;
            mosi      <= out_shift[CMD_BITS-1];
            out_shift <= {out_shift[CMD_BITS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_flash_stream_reader.sv
// SPI flash burst reader: READ/FAST_READ + 24-bit address, streams len bytes to a valid/ready consumer.
// Define SPI_FAST_READ_EN to use opcode 0x0B with 8 dummy clocks after the address.
module spi_flash_stream_reader
    import spi_flash_pkg::*;
#(
    parameter int unsigned LEN_W = 16
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [LEN_W-1:0]     len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

`ifdef SPI_FAST_READ_EN
    localparam bit FAST_READ = 1'b1;
`else
    localparam bit FAST_READ = 1'b0;
`endif

    localparam logic [7:0] OPCODE = FAST_READ ? CMD_FAST_READ : CMD_READ;

    state_t           state;
    logic [5:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic             accept;
    logic             load;
    logic             enable;
    logic             pause;
    logic             rise;
    logic             fall;
    logic [7:0]       rx_byte;

    assign accept = (state == ST_IDLE) && start && (len != '0);
    assign load   = accept && !abort;
    assign enable = (state == ST_CMD) || (state == ST_DUMMY) || (state == ST_DATA);
    // Hold SCLK low before a byte's 8th rise while the output register is still occupied.
    assign pause  = (state == ST_DATA) && (bit_cnt == 6'd7) && data_valid && !data_ready;

    spi_bit_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort),
        .load      (load),
        .load_word (cmd_word(OPCODE, addr)),
        .enable    (enable),
        .pause     (pause),
        .miso      (spi_miso),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .rx_byte   (rx_byte),
        .rise      (rise),
        .fall      (fall)
    );

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_CMD;
                        byte_cnt <= len;
                        bit_cnt  <= '0;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                ST_CMD: begin
                    if (rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end else if (fall && (bit_cnt == 6'(CMD_BITS))) begin
                        bit_cnt <= '0;
                        state   <= FAST_READ ? ST_DUMMY : ST_DATA;
                    end
                end

                ST_DUMMY: begin
                    if (rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end else if (fall && (bit_cnt == 6'(DUMMY_BITS))) begin
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end else if (fall && (bit_cnt == 6'd8)) begin
                        // Capture on the falling edge after the 8th rise; the register is free here.
                        bit_cnt    <= '0;
                        data       <= rx_byte;
                        data_valid <= 1'b1;
                        byte_cnt   <= byte_cnt - LEN_W'(1);
                        if (byte_cnt == LEN_W'(1)) begin
                            state    <= ST_END;
                            spi_cs_n <= 1'b1;
                        end
                    end
                end

                ST_END: begin
                    if (data_valid && data_ready) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// Self-checking bench for spi_flash_stream_reader with an SPI ROM model (byte[i] = i[7:0]).
// Honours SPI_FAST_READ_EN for opcode and first-data latency expectations.
module tb_spi_flash_stream_reader;

    localparam int unsigned LEN_W = 16;
`ifdef SPI_FAST_READ_EN
    localparam int unsigned DUMMY = 8;
    localparam logic [7:0]  OPC   = 8'h0B;
`else
    localparam int unsigned DUMMY = 0;
    localparam logic [7:0]  OPC   = 8'h03;
`endif
    // Bit k rises at N+2+2k; the first byte's last bit is k = 32+DUMMY+7, valid one cycle later.
    localparam int unsigned FIRST_VALID = 2 + 2 * (32 + DUMMY + 7) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             done;
    logic [7:0]       data;
    logic             data_valid;
    logic             data_ready;
    logic             spi_cs_n;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso = 1'b0;

    spi_flash_stream_reader #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .addr       (addr),
        .len        (len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SPI ROM model: samples MOSI on SCLK rise, presents MISO after SCLK fall.
    int unsigned cs_low_cnt    = 0;
    int unsigned rise_cnt      = 0;
    int unsigned sclk_idle_err = 0;
    int unsigned mosi_tail_err = 0;
    logic [31:0] cmd_rx        = '0;
    logic        prev_sclk     = 1'b0;
    logic        prev_cs       = 1'b1;

    always @(posedge clk) begin
        int unsigned dummy;
        int unsigned idx;
        logic [23:0] baddr;
        #2;
        if (spi_cs_n) begin
            if (spi_sclk) sclk_idle_err++;
            spi_miso = 1'b0;
        end else begin
            if (prev_cs) begin
                cs_low_cnt++;
                rise_cnt = 0;
                cmd_rx   = '0;
            end
            if (spi_sclk && !prev_sclk) begin
                if (rise_cnt < 32) cmd_rx = {cmd_rx[30:0], spi_mosi};
                else if (spi_mosi) mosi_tail_err++;
                rise_cnt++;
            end else if (!spi_sclk && prev_sclk) begin
                dummy = (cmd_rx[31:24] == 8'h0B) ? 8 : 0;
                if (rise_cnt >= 32 + dummy) begin
                    idx      = rise_cnt - 32 - dummy;
                    baddr    = cmd_rx[23:0] + 24'(idx / 8);
                    spi_miso = baddr[7 - (idx % 8)];
                end
            end
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    // kill_at: cycle after start at which abort (or reset if kill_rst) is pulsed; 0 = none.
    // restart_at: cycle at which a second start is pulsed while busy; 0 = none.
    task automatic run_burst(input logic [23:0] a, input int unsigned n, input bit rnd,
                             input int unsigned stall, input int unsigned kill_at,
                             input bit kill_rst, input int unsigned restart_at);
        int unsigned k, got, first_k, done_seen, stall_left, lows0, frozen_ref, stray;
        bit          expect_done, finished, killed;
        logic [23:0] ea;
        lows0 = cs_low_cnt; got = 0; first_k = 0; done_seen = 0; stall_left = stall;
        frozen_ref = 0; expect_done = 0; finished = 0; killed = 0; stray = 0;

        @(negedge clk);
        addr = a; len = LEN_W'(n); start = 1'b1; data_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; addr = 24'($urandom); len = LEN_W'($urandom);
        chk("start_cs_n", 32'(spi_cs_n), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_sclk", 32'(spi_sclk), 32'd0);
        chk("start_mosi", 32'(spi_mosi), 32'(OPC[7]));

        k = 1;
        while (k < 3000 && !finished) begin
            if (done) done_seen++;
            if (expect_done) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_cs_n_high", 32'(spi_cs_n), 32'd1);
                finished = 1;
                break;
            end
            if (killed) begin
                abort = 1'b0; reset = 1'b0;
                chk("kill_cs_n", 32'(spi_cs_n), 32'd1);
                chk("kill_busy", 32'(busy), 32'd0);
                chk("kill_valid", 32'(data_valid), 32'd0);
                chk("kill_sclk", 32'(spi_sclk), 32'd0);
                chk("kill_mosi", 32'(spi_mosi), 32'd0);
                finished = 1;
                break;
            end
            start = (k == restart_at);
            if (k == restart_at) begin addr = ~a; len = LEN_W'(3); end
            if (kill_at != 0 && k == kill_at) begin
                if (kill_rst) reset = 1'b1; else abort = 1'b1;
                killed = 1;
            end
            if (data_valid && first_k == 0) begin
                first_k = k;
                chk("first_valid_cycle", k, FIRST_VALID);
            end
            if (rnd) begin
                data_ready = 1'($urandom_range(0, 1));
            end else if (first_k != 0 && stall_left > 0) begin
                data_ready = 1'b0;
                if (stall_left == 20) frozen_ref = rise_cnt;
                if (stall_left == 1) begin
                    chk("stall_sclk_low", 32'(spi_sclk), 32'd0);
                    chk("stall_frozen", rise_cnt, frozen_ref);
                end
                stall_left--;
            end else begin
                data_ready = 1'b1;
            end
            if (data_valid && data_ready) begin
                ea = a + 24'(got);
                chk("data_byte", 32'(data), 32'(ea[7:0]));
                got++;
                if (got == n) expect_done = 1;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("burst_finished", 32'(finished), 32'd1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            if (killed && (data_valid || busy || !spi_cs_n)) stray++;
        end
        chk("cs_low_events", cs_low_cnt - lows0, 32'd1);
        if (killed) begin
            chk("kill_quiet", stray, 32'd0);
            chk("kill_no_done", done_seen, 32'd0);
        end else begin
            chk("done_count", done_seen, 32'd1);
            chk("bytes_received", got, n);
            chk("cmd_word", cmd_rx, {OPC, a});
            chk("sclk_rises", rise_cnt, 32 + DUMMY + 8 * n);
            chk("mosi_tail_zero", mosi_tail_err, 32'd0);
            chk("sclk_idle_cs_high", sclk_idle_err, 32'd0);
        end
    endtask

    initial begin
        int unsigned lows, stray;
        reset = 1'b1; start = 1'b0; addr = '0; len = '0; abort = 1'b0; data_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_cs_n", 32'(spi_cs_n), 32'd1);
            chk("idle_sclk", 32'(spi_sclk), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(data_valid), 32'd0);
        end

        run_burst(24'h000010, 4, 0, 0, 0, 0, 0);
        run_burst(24'h000010, 4, 0, 40, 0, 0, 0);

        lows = cs_low_cnt; stray = 0;
        @(negedge clk);
        addr = 24'h000123; len = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy || done || !spi_cs_n) stray++;
            @(negedge clk);
        end
        chk("len0_quiet", stray, 32'd0);
        chk("len0_no_cs", cs_low_cnt - lows, 32'd0);

        run_burst(24'h000040, 3, 0, 0, 0, 0, 10);
        run_burst(24'h000010, 4, 0, 0, 50, 0, 0);
        run_burst(24'h000020, 2, 0, 0, 0, 0, 0);
        run_burst(24'h000080, 4, 0, 0, 30, 1, 0);
        run_burst(24'h0000A0, 2, 0, 0, 0, 0, 0);
        run_burst(24'hFFFFFE, 4, 1, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            run_burst(24'($urandom), $urandom_range(1, 6), 1, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
